// File: rtl/char_tx.sv
// Byte-oriented UART transmitter: a small circular FIFO feeding an 8N1 serializer
// whose bit period is chosen per frame from a 3-bit baud select.
module char_tx #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [2:0]               i_baud,
    input  logic [7:0]               i_char,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_tx,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    data_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    state_t        state_reg, state_next;
    logic [12:0]   period_reg, period_next;
    logic [12:0]   cyc_reg, cyc_next;
    logic [2:0]    idx_reg, idx_next;
    logic          tx_reg, tx_next;
    logic          push;
    logic          pop;
    logic          bit_end;

    // Bit period in system clocks (23.04 MHz reference).
    function automatic logic [12:0] baud_period(input logic [2:0] sel);
        logic [12:0] p;
        case (sel)
            3'd0:    p = 13'd100;
            3'd1:    p = 13'd200;
            3'd2:    p = 13'd400;
            3'd3:    p = 13'd600;
            3'd4:    p = 13'd1200;
            3'd5:    p = 13'd2400;
            default: p = 13'd4800;
        endcase
        return p;
    endfunction

    assign o_ready = (count_reg < CW'(DEPTH));
    assign o_count = count_reg;
    assign o_tx    = tx_reg;
    assign o_busy  = (state_reg != IDLE);
    assign push    = i_valid && o_ready;
    assign bit_end = (cyc_reg == period_reg - 13'd1);

    always_comb begin
        state_next  = state_reg;
        period_next = period_reg;
        cyc_next    = cyc_reg + 13'd1;
        idx_next    = idx_reg;
        tx_next     = tx_reg;
        pop         = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_next  = 1'b1;
                cyc_next = '0;
                if (count_reg != '0) begin
                    pop         = 1'b1;
                    state_next  = START;
                    tx_next     = 1'b0;
                    period_next = baud_period(i_baud);
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    cyc_next   = '0;
                    idx_next   = 3'd0;
                    tx_next    = data_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_next = '0;
                    if (idx_reg == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        tx_next  = data_reg[idx_reg + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    cyc_next = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (count_reg != '0) begin
                        pop         = 1'b1;
                        state_next  = START;
                        tx_next     = 1'b0;
                        period_next = baud_period(i_baud);
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            period_reg <= 13'd100;
            cyc_reg    <= '0;
            idx_reg    <= '0;
            tx_reg     <= 1'b1;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            period_reg <= period_next;
            cyc_reg    <= cyc_next;
            idx_reg    <= idx_next;
            tx_reg     <= tx_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage and head-of-queue read kept free of reset so they map onto RAM.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_reg] <= i_char;
        if (pop)  data_reg <= mem[rd_ptr_reg];
    end

endmodule

// File: tb/tb_char_tx.sv
// Directed bench for char_tx: table-driven period and frame vectors plus
// hand-written sequences for FIFO-full, baud change, reset abort and push/pop overlap.
module tb_char_tx;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [2:0] i_baud = 3'd0;
    logic [7:0] i_char = 8'd0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic [2:0] o_count;

    int vectors = 0;
    int miscompares = 0;

    char_tx #(.DEPTH(4)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_baud  (i_baud),
        .i_char  (i_char),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_tx    (o_tx),
        .o_busy  (o_busy),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0] baud;
        int         period;
    } per_vec_t;

    typedef struct {
        logic [2:0] baud;
        logic [7:0] ch;
        logic [9:0] frame;
        int         period;
        int         nbits;
    } frm_vec_t;

    per_vec_t pv [8];
    frm_vec_t fv [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        i_char  = b;
        i_valid = 1'b1;
        step(1);
        i_valid = 1'b0;
    endtask

    // Asserted mid-cycle so the outputs must respond without a clock edge.
    task automatic do_reset();
        i_rst = 1'b1;
        #1;
        chk("rst_tx",    32'(o_tx),    32'd1);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        step(1);
        i_rst = 1'b0;
    endtask

    initial begin
        int busy_ones;
        int bad;
        int j;
        logic [7:0] eb;
        logic       exp_bit;

        pv[0] = '{3'd0, 100};
        pv[1] = '{3'd1, 200};
        pv[2] = '{3'd2, 400};
        pv[3] = '{3'd3, 600};
        pv[4] = '{3'd4, 1200};
        pv[5] = '{3'd5, 2400};
        pv[6] = '{3'd6, 4800};
        pv[7] = '{3'd7, 4800};

        fv[0] = '{3'd0, 8'h55, 10'b1010101010, 100,  10};
        fv[1] = '{3'd1, 8'h3C, 10'b1001111000, 200,  10};
        fv[2] = '{3'd2, 8'hA3, 10'b1101000110, 400,  10};
        fv[3] = '{3'd7, 8'hA3, 10'b1101000110, 4800, 4};

        #2;
        do_reset();
        $display("reset check done");

        // Start-bit length for every baud select, using 0xFF so the line rises right after.
        for (int i = 0; i < 8; i++) begin
            i_baud = pv[i].baud;
            push(8'hFF);
            step(1);
            chk("start_first", 32'(o_tx), 32'd0);
            step(pv[i].period - 1);
            chk("start_last",  32'(o_tx), 32'd0);
            step(1);
            chk("bit0_first",  32'(o_tx), 32'd1);
            $display("period vec %0d: baud %0d expects %0d clocks", i, pv[i].baud, pv[i].period);
            do_reset();
        end

        // Full or partial frames: first and last clock of each bit, busy duration.
        for (int i = 0; i < 4; i++) begin
            i_baud = fv[i].baud;
            push(fv[i].ch);
            step(1);
            busy_ones = 0;
            for (int c = 0; c < fv[i].nbits * fv[i].period; c++) begin
                if ((c % fv[i].period == 0) || (c % fv[i].period == fv[i].period - 1))
                    chk("frame_bit", 32'(o_tx), 32'(fv[i].frame[c / fv[i].period]));
                if (o_busy) busy_ones++;
                step(1);
            end
            chk("busy_len", 32'(busy_ones), 32'(fv[i].nbits * fv[i].period));
            if (fv[i].nbits == 10) begin
                chk("end_tx",   32'(o_tx),   32'd1);
                chk("end_busy", 32'(o_busy), 32'd0);
            end else begin
                do_reset();
            end
            $display("frame vec %0d: baud %0d char %02h bits %0d", i, fv[i].baud, fv[i].ch, fv[i].nbits);
        end

        // Six offered bytes into a 4-deep FIFO; all six leave back-to-back.
        i_baud = 3'd0;
        for (int b = 1; b <= 5; b++) begin
            i_char  = 8'(b);
            i_valid = 1'b1;
            step(1);
        end
        chk("full_count", 32'(o_count), 32'd4);
        chk("full_ready", 32'(o_ready), 32'd0);
        i_char    = 8'h06;
        busy_ones = 0;
        for (int c = 3; c <= 6000; c++) begin
            if (c == 999) begin
                chk("held_count", 32'(o_count), 32'd4);
                chk("held_ready", 32'(o_ready), 32'd0);
            end
            if (c == 1000) begin
                chk("gap_count", 32'(o_count), 32'd3);
                chk("gap_ready", 32'(o_ready), 32'd1);
                chk("gap_tx",    32'(o_tx),    32'd0);
            end
            if (c == 1001) begin
                chk("late_count", 32'(o_count), 32'd4);
                i_valid = 1'b0;
            end
            if (c < 6000) begin
                if (o_busy) busy_ones++;
                if (c % 100 == 50) begin
                    eb = 8'(c / 1000 + 1);
                    j  = (c % 1000) / 100;
                    exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : eb[j - 1];
                    chk("burst_bit", 32'(o_tx), 32'(exp_bit));
                end
            end else begin
                chk("burst_tx",    32'(o_tx),    32'd1);
                chk("burst_busy",  32'(o_busy),  32'd0);
                chk("burst_count", 32'(o_count), 32'd0);
            end
            step(1);
        end
        chk("burst_busy_len", 32'(busy_ones), 32'd5997);
        $display("burst sequence: 6 bytes offered at baud 0");

        // Baud select changed mid-frame only affects the following frame.
        i_baud = 3'd1;
        push(8'hFF);
        i_char  = 8'hFF;
        i_valid = 1'b1;
        step(1);
        i_valid = 1'b0;
        i_baud  = 3'd0;
        chk("bc_count", 32'(o_count), 32'd1);
        chk("bc_tx0",   32'(o_tx),    32'd0);
        step(199);
        chk("bc_199",   32'(o_tx),    32'd0);
        step(1);
        chk("bc_200",   32'(o_tx),    32'd1);
        step(1799);
        chk("bc_1999",  32'(o_tx),    32'd1);
        chk("bc_busy",  32'(o_busy),  32'd1);
        step(1);
        chk("bc_2000",  32'(o_tx),    32'd0);
        chk("bc_cnt0",  32'(o_count), 32'd0);
        step(99);
        chk("bc_2099",  32'(o_tx),    32'd0);
        step(1);
        chk("bc_2100",  32'(o_tx),    32'd1);
        step(899);
        chk("bc_2999",  32'(o_busy),  32'd1);
        step(1);
        chk("bc_end_tx",   32'(o_tx),   32'd1);
        chk("bc_end_busy", 32'(o_busy), 32'd0);
        $display("baud change sequence: 200 then 100 clocks per bit");

        // Reset in the middle of DATA with two bytes still queued.
        i_baud = 3'd0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("ra_count", 32'(o_count), 32'd2);
        step(349);
        chk("ra_busy",  32'(o_busy),  32'd1);
        do_reset();
        bad = 0;
        for (int c = 0; c < 1500; c++) begin
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_count !== 3'd0) bad++;
            step(1);
        end
        chk("ra_quiet", 32'(bad), 32'd0);
        push(8'h5A);
        step(1);
        chk("ra_new_tx",   32'(o_tx),   32'd0);
        chk("ra_new_busy", 32'(o_busy), 32'd1);
        do_reset();
        $display("reset abort sequence: 2 queued bytes discarded");

        // Push and pop on the same edge at the end of a stop bit.
        push(8'h21);
        push(8'h22);
        push(8'h23);
        push(8'h24);
        chk("pp_count3", 32'(o_count), 32'd3);
        step(997);
        chk("pp_pre_cnt", 32'(o_count), 32'd3);
        chk("pp_pre_tx",  32'(o_tx),    32'd1);
        chk("pp_pre_bsy", 32'(o_busy),  32'd1);
        push(8'h25);
        chk("pp_count",   32'(o_count), 32'd3);
        chk("pp_tx",      32'(o_tx),    32'd0);
        chk("pp_busy",    32'(o_busy),  32'd1);
        step(1);
        chk("pp_count_n", 32'(o_count), 32'd3);
        do_reset();
        $display("push/pop overlap sequence at count 3");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
